// File: rtl/fetch_group_sequencer.sv
// Latches one fetch group from the instruction buffer and feeds its valid slots,
// in slot order, to up to DEC_WIDTH decoder lanes per cycle until the group drains.
module fetch_group_sequencer #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DEC_WIDTH       = 2,
  parameter int ILEN            = 32,
  parameter int PLEN            = 32,
  parameter int CNTW            = 32,
  parameter bit ASSERT_EN       = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              ibuf_valid_i,
  output logic                              ibuf_ready_o,
  input  logic [INSTR_PER_FETCH-1:0]        ibuf_mask_i,
  input  logic [INSTR_PER_FETCH*ILEN-1:0]   ibuf_instrs_i,
  input  logic [INSTR_PER_FETCH*PLEN-1:0]   ibuf_pcs_i,
  output logic [DEC_WIDTH-1:0]              dec_valid_o,
  output logic [DEC_WIDTH*ILEN-1:0]         dec_instrs_o,
  output logic [DEC_WIDTH*PLEN-1:0]         dec_pcs_o,
  input  logic [$clog2(DEC_WIDTH+1)-1:0]    dec_accept_i,
  output logic                              busy_o,
  output logic [CNTW-1:0]                   stall_cnt_o
);

  localparam int AW = $clog2(DEC_WIDTH + 1);

  logic [INSTR_PER_FETCH-1:0] r_rem;
  logic [ILEN-1:0]            r_instrs [INSTR_PER_FETCH];
  logic [PLEN-1:0]            r_pcs    [INSTR_PER_FETCH];
  logic [CNTW-1:0]            r_stall_cnt;

  logic [INSTR_PER_FETCH-1:0] w_lane_oh [DEC_WIDTH];
  logic [DEC_WIDTH-1:0]       w_dec_valid;
  logic [AW-1:0]              w_nvalid;
  logic [AW-1:0]              w_acc_eff;
  logic [INSTR_PER_FETCH-1:0] w_clear;
  logic [INSTR_PER_FETCH-1:0] w_rem_next;
  logic                       w_load;

  // Each lane peels off the lowest remaining set bit, so lanes follow slot order.
  always_comb begin : lane_select
    logic [INSTR_PER_FETCH-1:0] w_left;
    // NOTE: every comb output gets a default before any conditional path so no latch is inferred.
    w_left = r_rem;
    for (int l = 0; l < DEC_WIDTH; l++) begin
      w_lane_oh[l]   = w_left & (~w_left + INSTR_PER_FETCH'(1));
      w_left         = w_left & ~w_lane_oh[l];
      w_dec_valid[l] = |w_lane_oh[l];
    end
  end

  always_comb begin
    dec_instrs_o = '0;
    dec_pcs_o    = '0;
    for (int l = 0; l < DEC_WIDTH; l++) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        if (w_lane_oh[l][s]) begin
          dec_instrs_o[l*ILEN +: ILEN] = r_instrs[s];
          dec_pcs_o[l*PLEN +: PLEN]    = r_pcs[s];
        end
      end
    end
  end

  // Over-accepting lanes is a protocol error; clamp it so the group stays consistent.
  always_comb begin
    w_nvalid = '0;
    for (int l = 0; l < DEC_WIDTH; l++) begin
      w_nvalid = w_nvalid + AW'(w_dec_valid[l]);
    end
    if (flush_i)                     w_acc_eff = '0;
    else if (dec_accept_i > w_nvalid) w_acc_eff = w_nvalid;
    else                             w_acc_eff = dec_accept_i;

    w_clear = '0;
    for (int l = 0; l < DEC_WIDTH; l++) begin
      if (AW'(l) < w_acc_eff) w_clear = w_clear | w_lane_oh[l];
    end
    w_rem_next = r_rem & ~w_clear;
  end

  assign ibuf_ready_o = !rst_i && !flush_i && (w_rem_next == '0);
  assign w_load       = ibuf_valid_i && ibuf_ready_o;
  assign dec_valid_o  = flush_i ? '0 : w_dec_valid;
  assign busy_o       = |r_rem;
  assign stall_cnt_o  = r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rem       <= '0;
      r_stall_cnt <= '0;
      // NOTE: the group store is tiny flop storage, so it is cleared on reset like any register.
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        r_instrs[s] <= '0;
        r_pcs[s]    <= '0;
      end
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (flush_i) begin
        r_rem <= '0;
      end else if (w_load) begin
        r_rem <= ibuf_mask_i;
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
          r_instrs[s] <= ibuf_instrs_i[s*ILEN +: ILEN];
          r_pcs[s]    <= ibuf_pcs_i[s*PLEN +: PLEN];
        end
      end else begin
        r_rem <= w_rem_next;
      end

      if (!flush_i && (w_dec_valid != '0) && (dec_accept_i == '0)) begin
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
    end
  end

  generate
    if (ASSERT_EN) begin : g_accept_check
      a_accept_within_valid: assert property (
        @(posedge clk_i) disable iff (rst_i || flush_i)
        dec_accept_i <= w_nvalid
      );
    end
  endgenerate

endmodule

// File: tb/tb_fetch_group_sequencer.sv
// Directed bench for fetch_group_sequencer: one task per scenario, inline checks
// against hand-computed lanes, PCs, handshake and stall-counter values.
module tb_fetch_group_sequencer;

  localparam int N    = 4;
  localparam int DW   = 2;
  localparam int ILEN = 32;
  localparam int PLEN = 32;
  localparam int CNTW = 32;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              ibuf_valid;
  logic              ibuf_ready;
  logic [N-1:0]      ibuf_mask;
  logic [N*ILEN-1:0] ibuf_instrs;
  logic [N*PLEN-1:0] ibuf_pcs;
  logic [DW-1:0]     dec_valid;
  logic [DW*ILEN-1:0] dec_instrs;
  logic [DW*PLEN-1:0] dec_pcs;
  logic [1:0]        accept;
  logic              busy;
  logic [CNTW-1:0]   stall_cnt;

  // Second instance with the protocol assertion disabled, for overshoot saturation.
  logic              s_flush;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_dec_valid;
  logic [DW*ILEN-1:0] s_dec_instrs;
  logic [DW*PLEN-1:0] s_dec_pcs;
  logic [1:0]        s_accept;
  logic              s_busy;
  logic [CNTW-1:0]   s_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_group_sequencer #(
    .INSTR_PER_FETCH(N), .DEC_WIDTH(DW), .ILEN(ILEN), .PLEN(PLEN), .CNTW(CNTW),
    .ASSERT_EN(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .ibuf_valid_i(ibuf_valid), .ibuf_ready_o(ibuf_ready),
    .ibuf_mask_i(ibuf_mask), .ibuf_instrs_i(ibuf_instrs), .ibuf_pcs_i(ibuf_pcs),
    .dec_valid_o(dec_valid), .dec_instrs_o(dec_instrs), .dec_pcs_o(dec_pcs),
    .dec_accept_i(accept), .busy_o(busy), .stall_cnt_o(stall_cnt)
  );

  fetch_group_sequencer #(
    .INSTR_PER_FETCH(N), .DEC_WIDTH(DW), .ILEN(ILEN), .PLEN(PLEN), .CNTW(CNTW),
    .ASSERT_EN(1'b0)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(s_flush),
    .ibuf_valid_i(s_valid), .ibuf_ready_o(s_ready),
    .ibuf_mask_i(ibuf_mask), .ibuf_instrs_i(ibuf_instrs), .ibuf_pcs_i(ibuf_pcs),
    .dec_valid_o(s_dec_valid), .dec_instrs_o(s_dec_instrs), .dec_pcs_o(s_dec_pcs),
    .dec_accept_i(s_accept), .busy_o(s_busy), .stall_cnt_o(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  function automatic logic [ILEN-1:0] f_instr(int g, int s);
    return 32'hA000_0000 + 32'(g * 16 + s);
  endfunction

  function automatic logic [PLEN-1:0] f_pc(int g, int s);
    return 32'h0000_1000 + 32'(g * 64 + s * 4);
  endfunction

  task automatic set_group(input int g, input logic [N-1:0] mask);
    ibuf_mask = mask;
    for (int s = 0; s < N; s++) begin
      ibuf_instrs[s*ILEN +: ILEN] = f_instr(g, s);
      ibuf_pcs[s*PLEN +: PLEN]    = f_pc(g, s);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_group(1, 4'b1111);
    ibuf_valid = 1'b1;
    accept     = 2'd0;
    step();
    ibuf_valid = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_hold: busy=%b required 1", busy);
    end
    step();
    n_tests++;
    if (stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL reset_pre_stall: stall_cnt=%0d required 1", stall_cnt);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({dec_valid, busy, ibuf_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in_reset: valid/busy/ready=%b required 0000",
                         {dec_valid, busy, ibuf_ready});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ibuf_ready !== 1'b1 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_release: ready=%b stall_cnt=%0d required ready=1 stall_cnt=0",
                         ibuf_ready, stall_cnt);
    end
    step();
  endtask

  task automatic test_full_group();
    set_group(2, 4'b1111);
    ibuf_valid = 1'b1;
    accept     = 2'd0;
    step();
    set_group(3, 4'b0011);
    accept = 2'd2;
    #1;
    n_tests++;
    if ({ibuf_ready, dec_valid, dec_instrs} !== {1'b0, 2'b11, f_instr(2, 1), f_instr(2, 0)}) begin
      n_fail++; $display("FAIL full_cycle1: ready=%b valid=%b instrs=%h required ready=0 valid=11 instrs=%h",
                         ibuf_ready, dec_valid, dec_instrs, {f_instr(2, 1), f_instr(2, 0)});
    end
    step();
    n_tests++;
    if ({ibuf_ready, dec_valid, dec_instrs} !== {1'b1, 2'b11, f_instr(2, 3), f_instr(2, 2)}) begin
      n_fail++; $display("FAIL full_cycle2: ready=%b valid=%b instrs=%h required ready=1 valid=11 instrs=%h",
                         ibuf_ready, dec_valid, dec_instrs, {f_instr(2, 3), f_instr(2, 2)});
    end
    n_tests++;
    if (dec_pcs !== {f_pc(2, 3), f_pc(2, 2)}) begin
      n_fail++; $display("FAIL full_cycle2_pcs: pcs=%h required %h", dec_pcs, {f_pc(2, 3), f_pc(2, 2)});
    end
    step();
    ibuf_valid = 1'b0;
    #1;
    n_tests++;
    if ({dec_valid, dec_instrs, dec_pcs} !== {2'b11, f_instr(3, 1), f_instr(3, 0), f_pc(3, 1), f_pc(3, 0)}) begin
      n_fail++; $display("FAIL full_next_group: valid=%b instrs=%h pcs=%h required group 3 slots 1/0",
                         dec_valid, dec_instrs, dec_pcs);
    end
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL full_drained: busy=%b required 0", busy);
    end
  endtask

  task automatic test_holes();
    set_group(4, 4'b1010);
    ibuf_valid = 1'b1;
    accept     = 2'd0;
    step();
    ibuf_valid = 1'b0;
    accept     = 2'd1;
    #1;
    n_tests++;
    if ({ibuf_ready, dec_valid, dec_instrs} !== {1'b0, 2'b11, f_instr(4, 3), f_instr(4, 1)}) begin
      n_fail++; $display("FAIL holes_cycle1: ready=%b valid=%b instrs=%h required ready=0 valid=11 instrs=%h",
                         ibuf_ready, dec_valid, dec_instrs, {f_instr(4, 3), f_instr(4, 1)});
    end
    step();
    n_tests++;
    if ({ibuf_ready, dec_valid, dec_instrs} !== {1'b1, 2'b01, 32'h0, f_instr(4, 3)}) begin
      n_fail++; $display("FAIL holes_cycle2: ready=%b valid=%b instrs=%h required ready=1 valid=01 instrs=%h",
                         ibuf_ready, dec_valid, dec_instrs, {32'h0, f_instr(4, 3)});
    end
    step();
    n_tests++;
    if ({busy, dec_valid} !== 3'b000) begin
      n_fail++; $display("FAIL holes_idle: busy/valid=%b required 000", {busy, dec_valid});
    end
  endtask

  task automatic test_back_pressure();
    logic [CNTW-1:0] s0;
    set_group(5, 4'b1111);
    ibuf_valid = 1'b1;
    accept     = 2'd0;
    step();
    ibuf_valid = 1'b0;
    s0 = stall_cnt;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({ibuf_ready, dec_valid, dec_instrs} !== {1'b0, 2'b11, f_instr(5, 1), f_instr(5, 0)}) begin
        n_fail++; $display("FAIL bp_hold_%0d: ready=%b valid=%b instrs=%h required ready=0 valid=11 instrs=%h",
                           i, ibuf_ready, dec_valid, dec_instrs, {f_instr(5, 1), f_instr(5, 0)});
      end
      step();
    end
    n_tests++;
    if (stall_cnt !== s0 + 32'd5) begin
      n_fail++; $display("FAIL bp_stall_cnt: stall_cnt=%0d required %0d", stall_cnt, s0 + 32'd5);
    end
    accept = 2'd2;
    step();
    n_tests++;
    if (dec_instrs !== {f_instr(5, 3), f_instr(5, 2)}) begin
      n_fail++; $display("FAIL bp_drain: instrs=%h required %h", dec_instrs, {f_instr(5, 3), f_instr(5, 2)});
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || stall_cnt !== s0 + 32'd5) begin
      n_fail++; $display("FAIL bp_done: busy=%b stall_cnt=%0d required busy=0 stall_cnt=%0d",
                         busy, stall_cnt, s0 + 32'd5);
    end
  endtask

  task automatic test_flush();
    logic [CNTW-1:0] s0;
    set_group(6, 4'b1111);
    ibuf_valid = 1'b1;
    accept     = 2'd0;
    step();
    ibuf_valid = 1'b0;
    accept     = 2'd2;
    step();
    set_group(7, 4'b1111);
    ibuf_valid = 1'b1;
    flush      = 1'b1;
    accept     = 2'd0;
    s0 = stall_cnt;
    #1;
    n_tests++;
    if ({busy, dec_valid, ibuf_ready} !== 4'b1000) begin
      n_fail++; $display("FAIL flush_cycle: busy/valid/ready=%b required 1000", {busy, dec_valid, ibuf_ready});
    end
    step();
    flush      = 1'b0;
    ibuf_valid = 1'b0;
    #1;
    n_tests++;
    if ({busy, dec_valid, ibuf_ready} !== 4'b0001 || stall_cnt !== s0) begin
      n_fail++; $display("FAIL flush_after: busy/valid/ready=%b stall_cnt=%0d required 0001 stall_cnt=%0d",
                         {busy, dec_valid, ibuf_ready}, stall_cnt, s0);
    end
  endtask

  task automatic test_edge();
    set_group(9, 4'b0000);
    ibuf_valid = 1'b1;
    accept     = 2'd0;
    #1;
    n_tests++;
    if (ibuf_ready !== 1'b1) begin
      n_fail++; $display("FAIL edge_zero_mask_ready: ready=%b required 1", ibuf_ready);
    end
    step();
    ibuf_valid = 1'b0;
    #1;
    n_tests++;
    if ({busy, dec_valid, ibuf_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL edge_zero_mask_drop: busy/valid/ready=%b required 0001",
                         {busy, dec_valid, ibuf_ready});
    end

    set_group(8, 4'b1111);
    s_valid  = 1'b1;
    s_accept = 2'd0;
    step();
    s_valid  = 1'b0;
    s_accept = 2'd3;
    #1;
    n_tests++;
    if ({s_ready, s_dec_valid, s_dec_instrs} !== {1'b0, 2'b11, f_instr(8, 1), f_instr(8, 0)}) begin
      n_fail++; $display("FAIL edge_overshoot: ready=%b valid=%b instrs=%h required ready=0 valid=11 instrs=%h",
                         s_ready, s_dec_valid, s_dec_instrs, {f_instr(8, 1), f_instr(8, 0)});
    end
    step();
    s_accept = 2'd2;
    #1;
    n_tests++;
    if ({s_busy, s_dec_valid, s_dec_instrs} !== {1'b1, 2'b11, f_instr(8, 3), f_instr(8, 2)}) begin
      n_fail++; $display("FAIL edge_saturated: busy=%b valid=%b instrs=%h required busy=1 valid=11 instrs=%h",
                         s_busy, s_dec_valid, s_dec_instrs, {f_instr(8, 3), f_instr(8, 2)});
    end
    step();
    n_tests++;
    if (s_busy !== 1'b0 || s_stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL edge_sat_done: busy=%b stall_cnt=%0d required busy=0 stall_cnt=0",
                         s_busy, s_stall_cnt);
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    ibuf_valid  = 1'b0;
    ibuf_mask   = '0;
    ibuf_instrs = '0;
    ibuf_pcs    = '0;
    accept      = 2'd0;
    s_flush     = 1'b0;
    s_valid     = 1'b0;
    s_accept    = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({ibuf_ready, busy, dec_valid} !== 4'b1000 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL init_idle: ready/busy/valid=%b stall_cnt=%0d required 1000 stall_cnt=0",
                         {ibuf_ready, busy, dec_valid}, stall_cnt);
    end
    step();

    test_reset();
    test_full_group();
    test_holes();
    test_back_pressure();
    test_flush();
    test_edge();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
